// File: rtl/qsys_pio_in_irq.sv
// rtl/qsys_pio_in_irq.sv - Avalon-MM input PIO with edge capture and masked level interrupt
// Optional build macro PIO_IN_BIT_CLEAR_EN: EDGECAP becomes write-1-to-clear instead of clear-all.
module qsys_pio_in_irq #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_raw, edge_det;
  logic [1:0]       warm_q, warm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_ok;

  assign wr_en     = chipselect & ~write_n;
  assign unused_ok = &{1'b0, writedata};

  always_comb begin
    edge_raw = '0;
    if (EDGE_TYPE == 0)      edge_raw = sync2_q & ~prev_q;
    else if (EDGE_TYPE == 1) edge_raw = ~sync2_q & prev_q;
    else                     edge_raw = sync2_q ^ prev_q;
  end

  // Until the synchroniser has filled, prev_q is still its reset value and would fake edges.
  assign edge_det = (warm_q == 2'd3) ? edge_raw : '0;
  assign warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) begin
`ifdef PIO_IN_BIT_CLEAR_EN
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
`else
      edgecap_d = '0;
`endif
    end
    // A fresh edge overrides a clear in the same cycle so it is never lost.
    edgecap_d = edgecap_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata_d[WIDTH-1:0] = sync2_q;
        2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
        2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      warm_q     <= 2'd0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      warm_q     <= warm_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_qsys_pio_in_irq.sv
// tb/tb_qsys_pio_in_irq.sv - self-checking bench for qsys_pio_in_irq (rising-edge and any-edge instances)
module tb_qsys_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'hFF;
  logic [7:0]  in_port2 = 8'h00;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    string       name;
  } rd_item_t;
  rd_item_t rd_q[$];

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic rd_req = 1'b0;
  logic rd_v_q = 1'b0;

  qsys_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  qsys_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_v_q <= rd_req;

  always @(negedge clk) begin
    if (rd_v_q) begin
      rd_item_t it;
      logic [31:0] act;
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: read data %08h with no expectation", readdata);
      end else begin
        it  = rd_q.pop_front();
        act = (it.dut == 0) ? readdata : readdata2;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input int which, input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_item_t it;
    it.dut = which; it.exp = exp; it.name = name;
    rd_q.push_back(it);
    address = a; chipselect = 1'b1; write_n = 1'b1; rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; rd_req = 1'b0;
  endtask

  vec_t vecs[10];
  logic [31:0] exp_cap;

  initial begin
    vecs[0] = '{1'b1, 2'd2, 32'hFFFF_FFA5};
    vecs[1] = '{1'b0, 2'd2, 32'h0000_00A5};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_0000};
    vecs[3] = '{1'b1, 2'd0, 32'h0000_0012};
    vecs[4] = '{1'b0, 2'd0, 32'h0000_00FF};
    vecs[5] = '{1'b1, 2'd1, 32'h0000_00FF};
    vecs[6] = '{1'b0, 2'd1, 32'h0000_0000};
    vecs[7] = '{1'b0, 2'd3, 32'h0000_0000};
    vecs[8] = '{1'b1, 2'd2, 32'h0000_0000};
    vecs[9] = '{1'b0, 2'd2, 32'h0000_0000};

    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    do_read(0, 2'd3, 32'h00, "warmup_edgecap");
    check("warmup_irq", {31'd0, irq}, 32'd0);
    do_read(0, 2'd0, 32'hFF, "warmup_data");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(0, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    check("no_cs_readdata_zero", readdata, 32'd0);

    in_port = 8'h00;
    repeat (5) @(negedge clk);
    do_write(2'd3, 32'hFF);
    do_write(2'd2, 32'h04);
    in_port = 8'h05;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("edge_before_3rd_clk_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("edge_3rd_clk_irq", {31'd0, irq}, 32'd1);
    do_read(0, 2'd3, 32'h05, "edgecap_05");

`ifdef PIO_IN_BIT_CLEAR_EN
    exp_cap = 32'h04;
`else
    exp_cap = 32'h00;
`endif
    do_write(2'd3, 32'h01);
    do_read(0, 2'd3, exp_cap, "clear_write_01");
    do_write(2'd2, 32'h01);
    check("mask01_irq", {31'd0, irq}, 32'd0);
    do_write(2'd2, 32'h04);
    check("mask04_irq", {31'd0, irq}, {31'd0, exp_cap[2]});

    do_write(2'd3, 32'hFF);
    in_port = 8'h07;
    @(posedge clk);
    @(posedge clk);
    do_write(2'd3, 32'hFF);
    do_read(0, 2'd3, 32'h02, "edge_beats_clear");
    check("collision_mask04_irq", {31'd0, irq}, 32'd0);
    do_write(2'd2, 32'h02);
    check("collision_mask02_irq", {31'd0, irq}, 32'd1);

    do_write(2'd3, 32'hFF);
    do_write(2'd2, 32'h08);
    in_port2 = 8'h08;
    repeat (4) @(negedge clk);
    do_read(1, 2'd3, 32'h08, "any_rise_cap");
    check("any_rise_irq", {31'd0, irq2}, 32'd1);
    do_write(2'd3, 32'hFF);
    check("any_cleared_irq", {31'd0, irq2}, 32'd0);
    in_port2 = 8'h00;
    repeat (4) @(negedge clk);
    do_read(1, 2'd3, 32'h08, "any_fall_cap");
    check("any_fall_irq", {31'd0, irq2}, 32'd1);

    address = 2'd3; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #2;
    check("pre_reset_readdata", readdata2, 32'h08);
    reset = 1'b1;
    #1;
    check("async_reset_irq", {31'd0, irq2}, 32'd0);
    check("async_reset_readdata", readdata2, 32'd0);
    @(negedge clk);
    chipselect = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_read(1, 2'd2, 32'h00, "post_reset_mask_any");
    do_read(0, 2'd2, 32'h00, "post_reset_mask");
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    @(negedge clk);
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qsys_pio_in_irq.md
# qsys_pio_in_irq

Avalon-MM slave input port: the read-side counterpart of the team's output PIO. It synchronises an external input bus into the `clk` domain and exposes the live value to the host. It latches per-bit edges into an edge-capture register and raises a level interrupt through a per-bit mask. It sits in the Qsys system next to the output PIO on the same slave bus, driven by the Nios/host master.

## Interface
Parameters:
- `WIDTH`, 8: input bus width, 1..32.
- `EDGE_TYPE`, 0: edge to capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 2: register word select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe, qualified by `chipselect`.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data, read latency 1.
- `in_port` input WIDTH: external asynchronous inputs.
- `irq` output 1: level interrupt, active-high.

## Operation
- Synchroniser: `in_port` passes through 2 flops (`sync1`, `sync2`), then a history flop `prev`. All three reset to 0.
- Edge detect per bit:
  - rising = `sync2 & ~prev`
  - falling = `~sync2 & prev`
  - any = `sync2 ^ prev`
- Warm-up counter (2 bits):
  - Reset to 0; increments each cycle until it saturates at 3.
  - Edge detection is gated off while the counter is below 3, so a high input at reset release never creates a false edge.
- Register map (word address):
  - 0 DATA, RO: `sync2`. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, RW: bits [WIDTH-1:0]. Upper bits read 0.
  - 3 EDGECAP, RW: sticky capture bits. Write behaviour is set under Configuration.
- Write occurs when `chipselect && !write_n`; `writedata[WIDTH-1:0]` is used.
- Read:
  - `readdata` is registered every cycle from the `address` mux.
  - Without `chipselect`, `readdata` is 0.
  - Unused upper bits are always 0.
- `irq = |(edgecap & irqmask)`, decoded combinationally from registers (no added delay).
- EDGECAP bit priority:
  - An edge detected and a clear in the same cycle: the edge wins and the bit stays 1.
  - A set on an already-set bit has no effect.
- IRQMASK changes affect `irq` in the same cycle the mask register updates.

## Timing
- Reset values:
  - `readdata` = 0, `irq` = 0.
  - IRQMASK = 0, EDGECAP = 0, `sync1`/`sync2`/`prev` = 0, warm-up counter = 0.
- Reset asserted mid-operation clears everything immediately, asynchronously. `irq` drops the same instant.
- Input to DATA: a change on `in_port` appears in `sync2` after 2 rising edges. It is readable on `readdata` 1 cycle after the read address is presented.
- Input to EDGECAP/`irq`: an edge at `in_port` sets EDGECAP on the 3rd rising `clk` edge, and `irq` rises with it.
- Write to register update: the register updates on the `clk` edge that samples the write. Effect on `irq` is visible the following cycle.
- Pulses shorter than one `clk` period may be missed. This is not an error condition.

## Configuration
- `PIO_IN_BIT_CLEAR_EN` defined:
  - A write to EDGECAP clears only the bits where `writedata` is 1 (write-1-to-clear).
  - Other bits keep their value.
- Not defined:
  - Any write to EDGECAP clears all capture bits, regardless of data.
- Register map, reset and `irq` behaviour are identical in both builds.

## Test plan
- Reset release with `in_port`=0xFF held high, WIDTH=8, EDGE_TYPE=0 -> after 10 cycles EDGECAP reads 0x00, `irq`=0, DATA reads 0xFF.
- `in_port` 0x00->0x05 with IRQMASK=0x04 -> EDGECAP=0x05 three cycles later; `irq`=1 on the same cycle.
- IRQMASK=0x01 with the EDGECAP=0x04 state -> `irq`=0.
- With the macro defined, EDGECAP=0x05, write 0x01 to address 3:
  - EDGECAP reads 0x04.
  - Repeating the write without the macro gives EDGECAP 0x00.
- Clear write to EDGECAP on the same cycle a new rising edge on bit 1 is detected -> bit 1 reads 1 afterwards; `irq` per mask.
- EDGE_TYPE=2, toggle bit 3 high then low (each held 4 cycles), clearing EDGECAP between them -> bit 3 captured on both edges.
- Reset asserted while `irq`=1 -> `irq` and `readdata` are 0 immediately; IRQMASK reads 0 after release.
